// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions, condition
// selectors, status codes, the "no register" ID and the NOP bubble fields.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ALUADD = 4'h0;
  localparam logic [3:0] ALUSUB = 4'h1;
  localparam logic [3:0] ALUAND = 4'h2;
  localparam logic [3:0] ALUXOR = 4'h3;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // Field values loaded by reset and by a bubble
  localparam logic [2:0] NOP_STAT  = SAOK;
  localparam logic [3:0] NOP_ICODE = INOP;
  localparam logic [3:0] NOP_IFUN  = 4'h0;

endpackage

// File: rtl/cc_eval.sv
// Condition evaluator: maps the condition-code register and a jXX/cmovXX
// function code onto the taken/not-taken outcome.
// Ports: zf/sf/of (current CC), ifun (condition selector), cnd (outcome).
module cc_eval
  import y86_pkg::*;
(
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic lt;
  assign lt = sf ^ of;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = lt | zf;
      C_L:     cnd = lt;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~lt;
      C_G:     cnd = ~lt & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register (bubble/stall), ALU operand and
// function selection, ALU, condition-code register and Cnd evaluation.
// Ports: clk/rst_n; E_stall/E_bubble pipeline control; d_* decode inputs;
// m_exc/W_exc suppress CC update; E_* registered pass-through; e_valE,
// e_dstE, e_Cnd combinational results; cc_zf/cc_sf/cc_of current CC.
module execute_stage
  import y86_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [2:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             m_exc,
  input  logic             W_exc,
  output logic [2:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [3:0]       E_dstM,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic [WIDTH-1:0] E_valA,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_Cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam logic [WIDTH-1:0] STEPV = WIDTH'(STEP);

  logic [WIDTH-1:0] E_valB, E_valC;
  logic [3:0]       E_dstE;
  logic [WIDTH-1:0] alua, alub;
  logic [3:0]       alufun;
  logic             f_zf, f_sf, f_of;
  logic             alu_ok, set_cc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      E_stat  <= NOP_STAT;
      E_icode <= NOP_ICODE;
      E_ifun  <= NOP_IFUN;
      E_valA  <= '0;
      E_valB  <= '0;
      E_valC  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!E_stall) begin
      E_stat  <= d_stat;
      E_icode <= d_icode;
      E_ifun  <= d_ifun;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_valC  <= d_valC;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_srcA  <= d_srcA;
      E_srcB  <= d_srcB;
    end
  end

  always_comb begin
    alua = '0;
    case (E_icode)
      IRRMOVQ, IOPQ:             alua = E_valA;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: alua = E_valC;
      ICALL, IPUSHQ:             alua = '0 - STEPV;
      IRET, IPOPQ:               alua = STEPV;
      default:                   alua = '0;
    endcase
  end

  always_comb begin
    alub = '0;
    case (E_icode)
      IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alub = E_valB;
      default:                                            alub = '0;
    endcase
  end

  assign alufun = (E_icode == IOPQ) ? E_ifun : ALUADD;

  always_comb begin
    e_valE = '0;
    f_of   = 1'b0;
    alu_ok = 1'b1;
    case (alufun)
      ALUADD: begin
        e_valE = alub + alua;
        f_of   = (alua[WIDTH-1] == alub[WIDTH-1]) && (e_valE[WIDTH-1] != alua[WIDTH-1]);
      end
      ALUSUB: begin
        e_valE = alub - alua;
        f_of   = (alua[WIDTH-1] != alub[WIDTH-1]) && (e_valE[WIDTH-1] != alub[WIDTH-1]);
      end
      ALUAND: e_valE = alub & alua;
      ALUXOR: e_valE = alub ^ alua;
      // Undefined OPq function: result forced to 0 and CC left alone
      default: alu_ok = 1'b0;
    endcase
  end

  assign f_zf = (e_valE == '0);
  assign f_sf = e_valE[WIDTH-1];

  assign set_cc = (E_icode == IOPQ) && alu_ok && !m_exc && !W_exc && (E_stat == SAOK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_zf <= 1'b1;
      cc_sf <= 1'b0;
      cc_of <= 1'b0;
    end else if (set_cc) begin
      cc_zf <= f_zf;
      cc_sf <= f_sf;
      cc_of <= f_of;
    end
  end

  cc_eval u_cc_eval (
    .zf   (cc_zf),
    .sf   (cc_sf),
    .of   (cc_of),
    .ifun (E_ifun),
    .cnd  (e_Cnd)
  );

  // A not-taken conditional move must not write its destination
  assign e_dstE = (E_icode == IRRMOVQ && !e_Cnd) ? RNONE : E_dstE;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import y86_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, E_stall, E_bubble, m_exc, W_exc;
  logic [2:0]   d_stat;
  logic [3:0]   d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [W-1:0] d_valA, d_valB, d_valC;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun, E_dstM, E_srcA, E_srcB, e_dstE;
  logic [W-1:0] E_valA, e_valE;
  logic         e_Cnd, cc_zf, cc_sf, cc_of;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage #(.WIDTH(W), .STEP(8)) dut (
    .clk(clk), .rst_n(rst_n), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_exc(m_exc), .W_exc(W_exc),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valA(E_valA),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one decoded instruction, then step past the edge that loads it
  task automatic load(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vc,
                      input logic [3:0] de);
    d_stat = st; d_icode = ic; d_ifun = fn;
    d_valA = va; d_valB = vb; d_valC = vc;
    d_dstE = de; d_dstM = 4'h1; d_srcA = 4'h2; d_srcB = 4'h3;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; E_stall = 1'b0; E_bubble = 1'b0; m_exc = 1'b0; W_exc = 1'b0;
    d_stat = SAOK; d_icode = INOP; d_ifun = 4'h0;
    d_valA = '0; d_valB = '0; d_valC = '0;
    d_dstE = RNONE; d_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_icode", 64'(E_icode), 64'h1);
    chk("rst_stat", 64'(E_stat), 64'h1);
    chk("rst_zf", 64'(cc_zf), 64'h1);
    rst_n = 1'b1;

    // add overflow
    load(SAOK, IOPQ, ALUADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h3);
    chk("add_valE", e_valE, 64'h8000_0000_0000_0000);
    chk("add_valA", E_valA, 64'h7FFF_FFFF_FFFF_FFFF);
    load(SAOK, INOP, 4'h0, '0, '0, '0, RNONE);
    chk("add_zf", 64'(cc_zf), 64'h0);
    chk("add_sf", 64'(cc_sf), 64'h1);
    chk("add_of", 64'(cc_of), 64'h1);

    // sub to zero, then cmovle taken
    load(SAOK, IOPQ, ALUSUB, 64'h5, 64'h5, 64'h0, 4'h2);
    chk("sub_valE", e_valE, 64'h0);
    load(SAOK, IRRMOVQ, C_LE, 64'h55, 64'h0, 64'h0, 4'h4);
    chk("sub_zf", 64'(cc_zf), 64'h1);
    chk("cmovle_cnd", 64'(e_Cnd), 64'h1);
    chk("cmovle_dstE", 64'(e_dstE), 64'h4);
    chk("cmovle_valE", e_valE, 64'h55);

    // xor, then cmovl not taken
    load(SAOK, IOPQ, ALUXOR, 64'hB, 64'hC, 64'h0, 4'h5);
    chk("xor_valE", e_valE, 64'h7);
    load(SAOK, IRRMOVQ, C_L, 64'h1, 64'h0, 64'h0, 4'h6);
    chk("xor_zf", 64'(cc_zf), 64'h0);
    chk("xor_of", 64'(cc_of), 64'h0);
    chk("cmovl_cnd", 64'(e_Cnd), 64'h0);
    chk("cmovl_dstE", 64'(e_dstE), 64'hF);

    // exceptions downstream block CC update
    m_exc = 1'b1;
    load(SAOK, IOPQ, ALUSUB, 64'h1, 64'h1, 64'h0, 4'h2);
    chk("mexc_valE", e_valE, 64'h0);
    load(SAOK, INOP, 4'h0, '0, '0, '0, RNONE);
    chk("mexc_zf", 64'(cc_zf), 64'h0);
    m_exc = 1'b0;
    W_exc = 1'b1;
    load(SAOK, IOPQ, ALUSUB, 64'h1, 64'h1, 64'h0, 4'h2);
    chk("wexc_valE", e_valE, 64'h0);
    load(SAOK, INOP, 4'h0, '0, '0, '0, RNONE);
    chk("wexc_zf", 64'(cc_zf), 64'h0);
    W_exc = 1'b0;

    // undefined OPq function
    load(SINS, IOPQ, 4'h4, 64'h3, 64'h5, 64'h0, 4'h2);
    chk("badfn_valE", e_valE, 64'h0);

    // stall holds, bubble beats stall
    load(SAOK, IOPQ, ALUADD, 64'h2, 64'h3, 64'h0, 4'h7);
    chk("pre_stall_valE", e_valE, 64'h5);
    E_stall = 1'b1;
    load(SAOK, IIRMOVQ, 4'h0, 64'h9, 64'h9, 64'h99, 4'h8);
    load(SAOK, IIRMOVQ, 4'h0, 64'h9, 64'h9, 64'h99, 4'h8);
    chk("stall_icode", 64'(E_icode), 64'h6);
    chk("stall_valE", e_valE, 64'h5);
    chk("stall_valA", E_valA, 64'h2);
    E_bubble = 1'b1;
    load(SAOK, IIRMOVQ, 4'h0, 64'h9, 64'h9, 64'h99, 4'h8);
    chk("bubble_icode", 64'(E_icode), 64'h1);
    chk("bubble_dstE", 64'(e_dstE), 64'hF);
    chk("bubble_valA", E_valA, 64'h0);
    E_bubble = 1'b0;
    E_stall = 1'b0;

    // immediate and stack-pointer arithmetic
    load(SAOK, IIRMOVQ, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h1);
    chk("irmov_valE", e_valE, 64'h1234);
    load(SAOK, IPUSHQ, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4);
    chk("push_valE", e_valE, 64'hF8);
    load(SAOK, IPOPQ, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4);
    chk("pop_valE", e_valE, 64'h108);

    // asynchronous reset mid-stream (CC currently ZF=0 from the 2+3 add)
    chk("pre_rst_zf", 64'(cc_zf), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_icode", 64'(E_icode), 64'h1);
    chk("arst_dstE", 64'(e_dstE), 64'hF);
    chk("arst_zf", 64'(cc_zf), 64'h1);
    chk("arst_sf", 64'(cc_sf), 64'h0);
    chk("arst_of", 64'(cc_of), 64'h0);
    @(posedge clk);
    rst_n = 1'b1;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
